costas_psk_tx_scheduler: RTL and testbench
==========================================

Name: costas_psk_tx_scheduler

Overview:
- Sequences the two beacon transmission modes, Costas-array FSK and PSK, and shares the single DDS and MCU trigger/clock interface between them.
- Latches transmission requests, arbitrates when both are pending, and starts each frame on a PPS edge.
- Generates the per-symbol MCU strobes and the DDS frequency-update pulse (fq_ud) for the active mode.
- Sits between the request inputs/PPS and the mcu_* / fq_ud outputs of the Costas top level.

Parameters:
- CLK_HZ, 27000000, sys_clk frequency.
- PSK_SIGNAL_RATE_HZ, 125, PSK symbol rate; PSK_SYM_CYCLES = CLK_HZ / PSK_SIGNAL_RATE_HZ (integer division).
- COSTAS_SYM_CYCLES, 2700000, sys_clk cycles per Costas symbol.
- COSTAS_LEN, 7, Costas symbols per frame (>=1).
- PSK_LEN, 128, PSK symbols per frame (>=1).
- GUARD_CYCLES, 27000, idle cycles after each frame before the next can start (>=1).
- PPS_TIMEOUT_CYCLES, 40500000, armed-wait limit, used only with the optional feature.

Ports:
- sys_clk  in  1  system clock (27 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- pps  in  1  1 Hz pulse, asynchronous to sys_clk.
- costas_txrq  in  1  Costas request, level or pulse, sampled each cycle.
- psk_txrq  in  1  PSK request, level or pulse, sampled each cycle.
- mcu_costas_trigger  out  1  high for the whole Costas frame.
- mcu_costas_clk  out  1  1-cycle pulse at each Costas symbol start.
- mcu_psk_trigger  out  1  high for the whole PSK frame.
- mcu_psk_clk  out  1  1-cycle pulse at each PSK symbol start.
- fq_ud  out  1  1-cycle DDS update pulse, coincident with every mcu_*_clk pulse.
- busy  out  1  high from frame start to end of guard.
- pps_lost  out  1  sticky timeout flag; constant 0 without the optional feature.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0): all outputs 0, state IDLE, both pending flags cleared, round-robin pointer set to Costas.
- Reset asserted mid-frame aborts the frame immediately; no completion pulses follow.
- PPS path: 2-flop synchronizer plus rising-edge detect. If E0 is the first sys_clk edge sampling pps=1, pps_edge is true at E2. A pps held high yields one edge only.
- Requests: a request high at edge E sets its pending flag at E. Pending is cleared only at the edge where that mode is granted.
  - A request arriving while its own mode runs is queued for the next PPS.
  - A request whose pending flag sets at the same edge as pps_edge is not eligible until the following PPS.
- FSM states: IDLE, COSTAS_RUN, PSK_RUN, GUARD.
- IDLE -> grant at a pps_edge edge when at least one flag was pending at the previous edge.
  - One pending: grant that mode.
  - Both pending: grant the mode pointed to by the round-robin pointer, then move the pointer to the other mode.
  - Nothing pending: stay in IDLE.
- Entering RUN at grant edge G:
  - mcu_<mode>_trigger = 1 and busy = 1 from G.
  - Symbol k (k = 0 .. LEN-1) pulses mcu_<mode>_clk and fq_ud for one cycle at G + k*SYM.
  - At G + LEN*SYM: trigger = 0, enter GUARD.
- GUARD: counts GUARD_CYCLES, then IDLE, with busy = 0 at that edge. A pps_edge during GUARD is ignored and pending stays set.
- Only one trigger is ever high at a time. fq_ud never pulses outside RUN.
- Symbol counter width: clog2(max(COSTAS_LEN, PSK_LEN) + 1). Cycle counter width: clog2(max(SYM cycles, GUARD_CYCLES, PPS_TIMEOUT_CYCLES) + 1). Neither counter wraps; each is reloaded at every state entry.

Optional Feature:
- Macro: COSTAS_PPS_TIMEOUT_EN.
- Defined:
  - If something is pending in IDLE and no pps_edge arrives within PPS_TIMEOUT_CYCLES of the first pending cycle, the scheduler grants anyway, using the normal arbitration, at the timeout edge.
  - pps_lost is set at that edge and stays set until reset.
  - Any pps_edge restarts the timeout count.
- Not defined: no timeout logic; grants occur only on pps_edge; pps_lost is tied to 0.

Test Plan:
- Overrides for all scenarios: CLK_HZ=1000, PSK_SIGNAL_RATE_HZ=100 (PSK_SYM_CYCLES=10), COSTAS_SYM_CYCLES=20, COSTAS_LEN=3, PSK_LEN=4, GUARD_CYCLES=5, PPS_TIMEOUT_CYCLES=200.
- Costas frame: costas_txrq pulse, pps rise sampled at E0 -> trigger high at E2; 3 clk/fq_ud pulses at E2, E22, E42; trigger low at E62; busy low at E67.
- Both pending after reset: first PPS -> Costas frame. Next PPS -> PSK frame of 4 pulses spaced 10 cycles, trigger high 40 cycles.
- No request: pps toggles for 3 periods -> all outputs stay 0.
- Re-request during own frame: psk_txrq during PSK_RUN, PPS during GUARD, then a later PPS -> exactly one further PSK frame, starting on the later PPS.
- Async reset at cycle 15 of a Costas frame -> trigger, busy and fq_ud are 0 within the same cycle; the next PPS without a new request produces no frame.
- With COSTAS_PPS_TIMEOUT_EN: costas_txrq, no pps -> grant at 200 cycles after pending set, pps_lost=1 and stays 1.

Source files
------------

// File: rtl/costas_psk_tx_scheduler.sv
// Costas/PSK beacon scheduler: latches requests, arbitrates round-robin, starts frames on PPS, drives MCU strobes and DDS fq_ud.
// Latency: grant registered 2 sys_clk edges after the first edge sampling pps=1; all outputs registered.
// No backpressure: requests are sticky until granted; COSTAS_PPS_TIMEOUT_EN adds a missing-PPS grant timeout and the pps_lost flag.
module costas_psk_tx_scheduler #(
    parameter int CLK_HZ             = 27000000,
    parameter int PSK_SIGNAL_RATE_HZ = 125,
    parameter int COSTAS_SYM_CYCLES  = 2700000,
    parameter int COSTAS_LEN         = 7,
    parameter int PSK_LEN            = 128,
    parameter int GUARD_CYCLES       = 27000,
    parameter int PPS_TIMEOUT_CYCLES = 40500000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic pps,
    input  logic costas_txrq,
    input  logic psk_txrq,
    output logic mcu_costas_trigger,
    output logic mcu_costas_clk,
    output logic mcu_psk_trigger,
    output logic mcu_psk_clk,
    output logic fq_ud,
    output logic busy,
    output logic pps_lost
);
    localparam int PSK_SYM_CYCLES = CLK_HZ / PSK_SIGNAL_RATE_HZ;
    localparam int MAX_LEN = (COSTAS_LEN > PSK_LEN) ? COSTAS_LEN : PSK_LEN;
    localparam int MAX_SYM = (COSTAS_SYM_CYCLES > PSK_SYM_CYCLES) ? COSTAS_SYM_CYCLES : PSK_SYM_CYCLES;
    localparam int MAX_SG  = (MAX_SYM > GUARD_CYCLES) ? MAX_SYM : GUARD_CYCLES;
    localparam int MAX_CYC = (MAX_SG > PPS_TIMEOUT_CYCLES) ? MAX_SG : PPS_TIMEOUT_CYCLES;
    localparam int SW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] COSTAS_SYM_LAST = CW'(COSTAS_SYM_CYCLES - 1);
    localparam logic [CW-1:0] PSK_SYM_LAST    = CW'(PSK_SYM_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST      = CW'(GUARD_CYCLES - 1);
    localparam logic [SW-1:0] COSTAS_LEN_LAST = SW'(COSTAS_LEN - 1);
    localparam logic [SW-1:0] PSK_LEN_LAST    = SW'(PSK_LEN - 1);
`ifdef COSTAS_PPS_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST    = CW'(PPS_TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, COSTAS_RUN, PSK_RUN, GUARD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cyc, cyc_nxt;
    logic [SW-1:0] sym, sym_nxt;
    logic          costas_pend, costas_pend_nxt;
    logic          psk_pend, psk_pend_nxt;
    logic          rr_psk, rr_psk_nxt;
    logic          costas_trig_nxt, costas_clk_nxt;
    logic          psk_trig_nxt, psk_clk_nxt;
    logic          fq_ud_nxt, busy_nxt, pps_lost_nxt;
    logic          grant, pick_psk;
    logic          pps_meta, pps_sync, pps_prev;
    logic          pps_edge;

    assign pps_edge = pps_sync & ~pps_prev;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cyc                <= '0;
            sym                <= '0;
            costas_pend        <= 1'b0;
            psk_pend           <= 1'b0;
            rr_psk             <= 1'b0;
            pps_meta           <= 1'b0;
            pps_sync           <= 1'b0;
            pps_prev           <= 1'b0;
            mcu_costas_trigger <= 1'b0;
            mcu_costas_clk     <= 1'b0;
            mcu_psk_trigger    <= 1'b0;
            mcu_psk_clk        <= 1'b0;
            fq_ud              <= 1'b0;
            busy               <= 1'b0;
            pps_lost           <= 1'b0;
        end else begin
            state              <= state_nxt;
            cyc                <= cyc_nxt;
            sym                <= sym_nxt;
            costas_pend        <= costas_pend_nxt;
            psk_pend           <= psk_pend_nxt;
            rr_psk             <= rr_psk_nxt;
            pps_meta           <= pps;
            pps_sync           <= pps_meta;
            pps_prev           <= pps_sync;
            mcu_costas_trigger <= costas_trig_nxt;
            mcu_costas_clk     <= costas_clk_nxt;
            mcu_psk_trigger    <= psk_trig_nxt;
            mcu_psk_clk        <= psk_clk_nxt;
            fq_ud              <= fq_ud_nxt;
            busy               <= busy_nxt;
            pps_lost           <= pps_lost_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cyc_nxt         = cyc;
        sym_nxt         = sym;
        // Arbitration uses the registered flags, so a request landing on the grant edge waits for the next PPS.
        costas_pend_nxt = costas_pend | costas_txrq;
        psk_pend_nxt    = psk_pend | psk_txrq;
        rr_psk_nxt      = rr_psk;
        costas_trig_nxt = mcu_costas_trigger;
        psk_trig_nxt    = mcu_psk_trigger;
        costas_clk_nxt  = 1'b0;
        psk_clk_nxt     = 1'b0;
        fq_ud_nxt       = 1'b0;
        busy_nxt        = busy;
        pps_lost_nxt    = pps_lost;
        grant           = 1'b0;
        pick_psk        = psk_pend & (~costas_pend | rr_psk);

        case (state)
            IDLE: begin
                if (costas_pend | psk_pend) begin
                    if (pps_edge) begin
                        grant = 1'b1;
                    end
`ifdef COSTAS_PPS_TIMEOUT_EN
                    else if (cyc == TIMEOUT_LAST) begin
                        grant        = 1'b1;
                        pps_lost_nxt = 1'b1;
                    end else begin
                        cyc_nxt = cyc + 1'b1;
                    end
`endif
                end
`ifdef COSTAS_PPS_TIMEOUT_EN
                else begin
                    cyc_nxt = '0;
                end
`endif
                if (grant) begin
                    state_nxt = pick_psk ? PSK_RUN : COSTAS_RUN;
                    if (costas_pend & psk_pend) begin
                        rr_psk_nxt = ~pick_psk;
                    end
                    if (pick_psk) begin
                        psk_pend_nxt = psk_txrq;
                        psk_trig_nxt = 1'b1;
                        psk_clk_nxt  = 1'b1;
                    end else begin
                        costas_pend_nxt = costas_txrq;
                        costas_trig_nxt = 1'b1;
                        costas_clk_nxt  = 1'b1;
                    end
                    fq_ud_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    cyc_nxt   = '0;
                    sym_nxt   = '0;
                end
            end
            COSTAS_RUN, PSK_RUN: begin
                if (cyc == ((state == PSK_RUN) ? PSK_SYM_LAST : COSTAS_SYM_LAST)) begin
                    cyc_nxt = '0;
                    if (sym == ((state == PSK_RUN) ? PSK_LEN_LAST : COSTAS_LEN_LAST)) begin
                        state_nxt       = GUARD;
                        costas_trig_nxt = 1'b0;
                        psk_trig_nxt    = 1'b0;
                        sym_nxt         = '0;
                    end else begin
                        sym_nxt   = sym + 1'b1;
                        fq_ud_nxt = 1'b1;
                        if (state == PSK_RUN) begin
                            psk_clk_nxt = 1'b1;
                        end else begin
                            costas_clk_nxt = 1'b1;
                        end
                    end
                end else begin
                    cyc_nxt = cyc + 1'b1;
                end
            end
            GUARD: begin
                // PPS edges seen here are dropped; pending flags simply carry over.
                if (cyc == GUARD_LAST) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    cyc_nxt   = '0;
                end else begin
                    cyc_nxt = cyc + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_costas_psk_tx_scheduler.sv
// Scoreboarded bench for costas_psk_tx_scheduler: expected output transitions are queued when PPS is driven
// and matched against transitions observed on the DUT outputs.
module tb_costas_psk_tx_scheduler;
    localparam int COSTAS_SYM = 20;
    localparam int PSK_SYM    = 10;
    localparam int C_LEN      = 3;
    localparam int P_LEN      = 4;
    localparam int GUARD      = 5;

    localparam int EV_BUSY_ON   = 1;
    localparam int EV_CTRIG_ON  = 2;
    localparam int EV_PTRIG_ON  = 3;
    localparam int EV_CCLK      = 4;
    localparam int EV_PCLK      = 5;
    localparam int EV_CTRIG_OFF = 6;
    localparam int EV_PTRIG_OFF = 7;
    localparam int EV_BUSY_OFF  = 8;

    logic sys_clk = 1'b0;
    logic rst_n = 1'b0;
    logic pps = 1'b0;
    logic costas_txrq = 1'b0;
    logic psk_txrq = 1'b0;
    logic mcu_costas_trigger, mcu_costas_clk, mcu_psk_trigger, mcu_psk_clk;
    logic fq_ud, busy, pps_lost;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {
        int kind;
        int cycle;
    } ev_t;
    ev_t exp_q[$];

    costas_psk_tx_scheduler #(
        .CLK_HZ(1000),
        .PSK_SIGNAL_RATE_HZ(100),
        .COSTAS_SYM_CYCLES(COSTAS_SYM),
        .COSTAS_LEN(C_LEN),
        .PSK_LEN(P_LEN),
        .GUARD_CYCLES(GUARD),
        .PPS_TIMEOUT_CYCLES(200)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .pps(pps),
        .costas_txrq(costas_txrq),
        .psk_txrq(psk_txrq),
        .mcu_costas_trigger(mcu_costas_trigger),
        .mcu_costas_clk(mcu_costas_clk),
        .mcu_psk_trigger(mcu_psk_trigger),
        .mcu_psk_clk(mcu_psk_clk),
        .fq_ud(fq_ud),
        .busy(busy),
        .pps_lost(pps_lost)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int cycle);
        ev_t e;
        e.kind  = kind;
        e.cycle = cycle;
        exp_q.push_back(e);
    endtask

    // Expected transitions of one frame granted at edge g, in the order the monitor reports them.
    task automatic push_frame(input bit is_psk, input int g);
        int len = is_psk ? P_LEN : C_LEN;
        int sym = is_psk ? PSK_SYM : COSTAS_SYM;
        push_ev(EV_BUSY_ON, g);
        push_ev(is_psk ? EV_PTRIG_ON : EV_CTRIG_ON, g);
        for (int k = 0; k < len; k++) push_ev(is_psk ? EV_PCLK : EV_CCLK, g + k * sym);
        push_ev(is_psk ? EV_PTRIG_OFF : EV_CTRIG_OFF, g + len * sym);
        push_ev(EV_BUSY_OFF, g + len * sym + GUARD);
    endtask

    task automatic got_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_event", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq("event_kind", kind, e.kind);
            check_eq("event_cycle", cyc, e.cycle);
        end
    endtask

    logic p_busy = 1'b0, p_ct = 1'b0, p_pt = 1'b0;
    always @(negedge sys_clk) begin
        if (busy && !p_busy) got_event(EV_BUSY_ON);
        if (mcu_costas_trigger && !p_ct) got_event(EV_CTRIG_ON);
        if (mcu_psk_trigger && !p_pt) got_event(EV_PTRIG_ON);
        if (mcu_costas_clk) got_event(EV_CCLK);
        if (mcu_psk_clk) got_event(EV_PCLK);
        if (!mcu_costas_trigger && p_ct) got_event(EV_CTRIG_OFF);
        if (!mcu_psk_trigger && p_pt) got_event(EV_PTRIG_OFF);
        if (!busy && p_busy) got_event(EV_BUSY_OFF);
        check_eq("fq_ud_with_clk", fq_ud, mcu_costas_clk | mcu_psk_clk);
        check_eq("single_trigger", mcu_costas_trigger & mcu_psk_trigger, 0);
        check_eq("clk_inside_frame", (mcu_costas_clk & ~mcu_costas_trigger) | (mcu_psk_clk & ~mcu_psk_trigger), 0);
`ifndef COSTAS_PPS_TIMEOUT_EN
        check_eq("pps_lost_tied", pps_lost, 0);
`endif
        p_busy = busy;
        p_ct   = mcu_costas_trigger;
        p_pt   = mcu_psk_trigger;
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    task automatic req_pulse(input bit c, input bit p);
        @(negedge sys_clk);
        costas_txrq = c;
        psk_txrq    = p;
        @(negedge sys_clk);
        costas_txrq = 1'b0;
        psk_txrq    = 1'b0;
    endtask

    // kind: 0 no frame expected, 1 Costas frame, 2 PSK frame; g is the expected grant edge.
    task automatic pps_frame(input int kind, output int g);
        @(negedge sys_clk);
        g = cyc + 3;
        if (kind == 1) push_frame(1'b0, g);
        else if (kind == 2) push_frame(1'b1, g);
        pps = 1'b1;
        repeat (3) @(negedge sys_clk);
        pps = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int g, g2, p;
        repeat (3) @(negedge sys_clk);
        check_eq("rst_costas_trigger", mcu_costas_trigger, 0);
        check_eq("rst_costas_clk", mcu_costas_clk, 0);
        check_eq("rst_psk_trigger", mcu_psk_trigger, 0);
        check_eq("rst_psk_clk", mcu_psk_clk, 0);
        check_eq("rst_fq_ud", fq_ud, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pps_lost", pps_lost, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Single Costas frame
        req_pulse(1'b1, 1'b0);
        pps_frame(1, g);
        wait_until(g + 75);

        // Both pending: Costas first, PSK on the following PPS
        req_pulse(1'b1, 1'b1);
        pps_frame(1, g);
        wait_until(g + 75);
        pps_frame(2, g);
        wait_until(g + 55);

        // No requests: PPS alone does nothing
        for (int i = 0; i < 3; i++) begin
            pps_frame(0, g);
            repeat (10) @(negedge sys_clk);
        end
        check_eq("idle_busy", busy, 0);
        check_eq("idle_triggers", mcu_costas_trigger | mcu_psk_trigger, 0);

        // Re-request during own PSK frame: PPS in guard ignored, later PPS runs it once
        req_pulse(1'b0, 1'b1);
        pps_frame(2, g);
        wait_until(g + 10);
        req_pulse(1'b0, 1'b1);
        wait_until(g + 40);
        pps_frame(0, g2);
        check_eq("guard_pps_busy", busy, 0);
        pps_frame(2, g2);
        wait_until(g2 + 55);
        pps_frame(0, g);
        repeat (10) @(negedge sys_clk);

        // Async reset at cycle 15 of a Costas frame
        req_pulse(1'b1, 1'b0);
        pps_frame(1, g);
        wait_until(g + 15);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        push_ev(EV_CTRIG_OFF, cyc + 1);
        push_ev(EV_BUSY_OFF, cyc + 1);
        #1;
        check_eq("abort_trigger", mcu_costas_trigger, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_fq_ud", fq_ud, 0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        pps_frame(0, g);
        repeat (20) @(negedge sys_clk);

`ifdef COSTAS_PPS_TIMEOUT_EN
        // Missing PPS: grant on timeout and raise sticky pps_lost
        check_eq("pps_lost_before", pps_lost, 0);
        @(negedge sys_clk);
        costas_txrq = 1'b1;
        p = cyc + 1;
        push_frame(1'b0, p + 200);
        @(negedge sys_clk);
        costas_txrq = 1'b0;
        wait_until(p + 199);
        check_eq("pps_lost_pre_timeout", pps_lost, 0);
        wait_until(p + 200);
        check_eq("pps_lost_set", pps_lost, 1);
        wait_until(p + 280);
        check_eq("pps_lost_sticky", pps_lost, 1);
`else
        p = 0;
`endif

        check_eq("exp_queue_empty", exp_q.size(), 0 + p * 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
